enemy_beam: RTL and testbench

Enemy projectile engine for the shooter game: on a `fire` request it latches the firing enemy's position, then moves the beam downward one step per movement tick. It terminates on the first of three events: an external block (shield or beam collision), a hit on the player ship, or reaching the bottom of the play field. It pairs with the upward-moving player beam. It feeds the VGA draw/erase logic (`x`, `y`, `active`, `mv_d`) and the game-state logic (`player_hit`).

---
 rtl/enemy_beam.sv | 246 ++++++++++++++++++++++++
 tb/tb_enemy_beam.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/enemy_beam.sv
// Enemy projectile engine: latches the firing enemy's position, drops the beam
// one STEP per movement tick, and ends on block, ship hit or bottom of field.
module enemy_beam #(
  parameter int TICK_DIV        = 833334,
  parameter int FRAMES_PER_STEP = 4,
  parameter int STEP            = 4,
  parameter int Y_BOTTOM        = 116,
  parameter int SHIP_Y          = 112,
  parameter int SHIP_W          = 8,
  parameter int COOLDOWN        = 30
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       fire,
  input  logic [7:0] enemy_x,
  input  logic [6:0] enemy_y,
  input  logic [7:0] ship_x,
  input  logic       blocked,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic       active,
  output logic       mv_d,
  output logic       player_hit
);

  localparam int CW  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int FW  = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
  localparam int KW  = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;

  localparam logic [CW-1:0] CYC_LAST   = CW'(TICK_DIV - 1);
  localparam logic [FW-1:0] FRM_LAST   = FW'(FRAMES_PER_STEP - 1);
  localparam logic [KW-1:0] COOL_LOAD  = KW'(COOLDOWN);
  localparam logic [7:0]    STEP8      = 8'(STEP);
  localparam logic [7:0]    Y_BOT8     = 8'(Y_BOTTOM);
  localparam logic [6:0]    Y_BOT7     = 7'(Y_BOTTOM);
  localparam logic [7:0]    SHIP_Y8    = 8'(SHIP_Y);
  localparam logic [8:0]    SHIP_W_M1  = 9'(SHIP_W - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_DOWN = 3'd2,
    S_HIT  = 3'd3,
    S_END  = 3'd4,
    S_COOL = 3'd5
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;

  logic [CW-1:0]   r_cyc;
  logic [FW-1:0]   r_frm;
  logic [KW-1:0]   r_cool;
  logic [KW-1:0]   w_cool_nxt;

  logic [7:0]      r_x;
  logic [6:0]      r_y;
  logic [7:0]      w_x_nxt;
  logic [6:0]      w_y_nxt;

  logic            r_active;
  logic            r_mv_d;
  logic            r_hit;
  logic            w_active_nxt;
  logic            w_mv_d_nxt;
  logic            w_hit_nxt;

  logic            w_frame_tick;
  logic            w_step_tick;
  logic [7:0]      w_ny;
  logic [8:0]      w_x9;
  logic [8:0]      w_ship_lo;
  logic [8:0]      w_ship_hi;
  logic            w_in_ship_col;
  logic            w_spawn_low;

  assign w_frame_tick  = (r_cyc == CYC_LAST);
  assign w_step_tick   = w_frame_tick && (r_frm == FRM_LAST);

  // Next row is formed in 8 bits so a 7-bit wrap cannot hide the bottom.
  assign w_ny          = {1'b0, r_y} + STEP8;
  assign w_x9          = {1'b0, r_x};
  assign w_ship_lo     = {1'b0, ship_x};
  assign w_ship_hi     = {1'b0, ship_x} + SHIP_W_M1;
  assign w_in_ship_col = (w_x9 >= w_ship_lo) && (w_x9 <= w_ship_hi);
  assign w_spawn_low   = ({1'b0, enemy_y} >= Y_BOT8);

  // Free-running cycle and frame counters; the FSM never restarts them.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cyc <= '0;
      r_frm <= '0;
    end else begin
      if (w_frame_tick) begin
        r_cyc <= '0;
        if (r_frm == FRM_LAST) begin
          r_frm <= '0;
        end else begin
          r_frm <= r_frm + FW'(1);
        end
      end else begin
        r_cyc <= r_cyc + CW'(1);
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and datapath update logic.
  always_comb begin
    w_state_nxt = r_state;
    w_x_nxt     = r_x;
    w_y_nxt     = r_y;
    w_cool_nxt  = r_cool;
    case (r_state)
      S_IDLE: begin
        if (fire && (r_cool == '0)) begin
          w_state_nxt = S_LOAD;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_LOAD: begin
        w_x_nxt = enemy_x;
        w_y_nxt = enemy_y;
        if (w_spawn_low) begin
          w_state_nxt = S_END;
        end else begin
          w_state_nxt = S_DOWN;
        end
      end
      S_DOWN: begin
        // An external block wins over a same-cycle hit or landing.
        if (blocked) begin
          w_state_nxt = S_END;
        end else if (w_step_tick) begin
          if ((w_ny >= SHIP_Y8) && w_in_ship_col) begin
            w_state_nxt = S_HIT;
            if (w_ny >= Y_BOT8) begin
              w_y_nxt = Y_BOT7;
            end else begin
              w_y_nxt = w_ny[6:0];
            end
          end else if (w_ny >= Y_BOT8) begin
            w_state_nxt = S_END;
            w_y_nxt     = Y_BOT7;
          end else begin
            w_state_nxt = S_DOWN;
            w_y_nxt     = w_ny[6:0];
          end
        end else begin
          w_state_nxt = S_DOWN;
        end
      end
      S_HIT: begin
        w_state_nxt = S_END;
      end
      S_END: begin
        w_cool_nxt  = COOL_LOAD;
        w_state_nxt = S_COOL;
      end
      S_COOL: begin
        if (r_cool == '0) begin
          w_state_nxt = S_IDLE;
        end else if (w_frame_tick) begin
          w_cool_nxt = r_cool - KW'(1);
          if (r_cool == KW'(1)) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_state_nxt = S_COOL;
          end
        end else begin
          w_state_nxt = S_COOL;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Beam position and cooldown registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_x    <= 8'd0;
      r_y    <= 7'd0;
      r_cool <= '0;
    end else begin
      r_x    <= w_x_nxt;
      r_y    <= w_y_nxt;
      r_cool <= w_cool_nxt;
    end
  end

  // Moore output decode from the current state.
  always_comb begin
    w_active_nxt = 1'b0;
    w_mv_d_nxt   = 1'b0;
    w_hit_nxt    = 1'b0;
    case (r_state)
      S_LOAD: begin
        w_active_nxt = 1'b1;
      end
      S_DOWN: begin
        w_active_nxt = 1'b1;
        w_mv_d_nxt   = 1'b1;
      end
      S_HIT: begin
        w_active_nxt = 1'b1;
        w_hit_nxt    = 1'b1;
      end
      default: begin
        w_active_nxt = 1'b0;
        w_mv_d_nxt   = 1'b0;
        w_hit_nxt    = 1'b0;
      end
    endcase
  end

  // Registered status outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_active <= 1'b0;
      r_mv_d   <= 1'b0;
      r_hit    <= 1'b0;
    end else begin
      r_active <= w_active_nxt;
      r_mv_d   <= w_mv_d_nxt;
      r_hit    <= w_hit_nxt;
    end
  end

  assign x          = r_x;
  assign y          = r_y;
  assign active     = r_active;
  assign mv_d       = r_mv_d;
  assign player_hit = r_hit;

endmodule

// File: tb/tb_enemy_beam.sv
// Directed bench for enemy_beam with a 4-cycle frame and 8-cycle step period;
// every step edge is a multiple of 8 cycles after reset release.
module tb_enemy_beam;

  logic       clk = 1'b0;
  logic       resetn;
  logic       fire;
  logic [7:0] enemy_x;
  logic [6:0] enemy_y;
  logic [7:0] ship_x;
  logic       blocked;
  logic [7:0] x;
  logic [6:0] y;
  logic       active;
  logic       mv_d;
  logic       player_hit;

  int          checks = 0;
  int          errors = 0;
  int          cyc;
  logic [31:0] hit_cnt = 32'd0;
  logic [31:0] act_hi;

  enemy_beam #(
    .TICK_DIV(4), .FRAMES_PER_STEP(2), .STEP(4), .Y_BOTTOM(116),
    .SHIP_Y(112), .SHIP_W(8), .COOLDOWN(2)
  ) dut (
    .clk(clk), .resetn(resetn), .fire(fire), .enemy_x(enemy_x),
    .enemy_y(enemy_y), .ship_x(ship_x), .blocked(blocked), .x(x), .y(y),
    .active(active), .mv_d(mv_d), .player_hit(player_hit)
  );

  always #5 clk = ~clk;

  // Rising edges since reset release.
  always @(posedge clk or negedge resetn) begin
    if (!resetn) cyc <= 0;
    else         cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    if (player_hit === 1'b1) hit_cnt <= hit_cnt + 32'd1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d (cyc=%0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic wait_to(input int k);
    if (cyc > k) begin
      chk("schedule", 32'(cyc), 32'(k));
    end
    while (cyc < k) @(negedge clk);
  endtask

  initial begin
    resetn = 1'b0; fire = 1'b0; enemy_x = 8'd0; enemy_y = 7'd0;
    ship_x = 8'd0; blocked = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_x", 32'(x), 32'd0);
    chk("rst_y", 32'(y), 32'd0);
    chk("rst_active", 32'(active), 32'd0);
    chk("rst_mv_d", 32'(mv_d), 32'd0);
    chk("rst_hit", 32'(player_hit), 32'd0);
    resetn = 1'b1;

    // Fall to bottom, no ship in the column.
    fire = 1'b1; enemy_x = 8'd20; enemy_y = 7'd100; ship_x = 8'd100;
    wait_to(1);  fire = 1'b0;
    chk("lat_active_load", 32'(active), 32'd0);
    wait_to(2);
    chk("fall_active", 32'(active), 32'd1);
    chk("fall_x", 32'(x), 32'd20);
    chk("fall_y0", 32'(y), 32'd100);
    chk("fall_mvd_load", 32'(mv_d), 32'd0);
    wait_to(3);  chk("fall_mvd_down", 32'(mv_d), 32'd1);
    wait_to(7);  chk("fall_y_pre", 32'(y), 32'd100);
    wait_to(8);  chk("fall_y1", 32'(y), 32'd104);
    wait_to(16); chk("fall_y2", 32'(y), 32'd108);
    wait_to(24); chk("fall_y3", 32'(y), 32'd112);
    wait_to(31); chk("fall_y3_hold", 32'(y), 32'd112);
    wait_to(32);
    chk("fall_clamp", 32'(y), 32'd116);
    chk("fall_active_end", 32'(active), 32'd1);
    wait_to(33);
    chk("fall_active_off", 32'(active), 32'd0);
    chk("fall_mvd_off", 32'(mv_d), 32'd0);
    chk("fall_no_hit", hit_cnt, 32'd0);

    // Fire held through cooldown, then a ship hit.
    fire = 1'b1; enemy_x = 8'd55; enemy_y = 7'd100; ship_x = 8'd50;
    wait_to(41);
    chk("cool_hold_active", 32'(active), 32'd0);
    chk("cool_hold_x", 32'(x), 32'd20);
    wait_to(42); fire = 1'b0;
    chk("hit_active", 32'(active), 32'd1);
    chk("hit_x", 32'(x), 32'd55);
    chk("hit_y0", 32'(y), 32'd100);
    wait_to(50); fire = 1'b1; enemy_x = 8'd99; enemy_y = 7'd5;
    wait_to(51); fire = 1'b0; enemy_x = 8'd55; enemy_y = 7'd100;
    wait_to(52);
    chk("ignfire_x", 32'(x), 32'd55);
    chk("ignfire_y", 32'(y), 32'd104);
    chk("ignfire_mvd", 32'(mv_d), 32'd1);
    wait_to(64);
    chk("hit_y", 32'(y), 32'd112);
    chk("hit_pre", 32'(player_hit), 32'd0);
    wait_to(65);
    chk("hit_pulse", 32'(player_hit), 32'd1);
    chk("hit_active_hit", 32'(active), 32'd1);
    wait_to(66);
    chk("hit_pulse_end", 32'(player_hit), 32'd0);
    chk("hit_active_off", 32'(active), 32'd0);
    chk("hit_count", hit_cnt, 32'd1);

    // Right edge of ship column + 1: a miss.
    wait_to(72); fire = 1'b1; enemy_x = 8'd58; enemy_y = 7'd100; ship_x = 8'd50;
    wait_to(73); fire = 1'b0;
    wait_to(74); chk("miss_x", 32'(x), 32'd58);
    wait_to(96); chk("miss_y3", 32'(y), 32'd112);
    wait_to(104);
    chk("miss_clamp", 32'(y), 32'd116);
    chk("miss_active", 32'(active), 32'd1);
    wait_to(105);
    chk("miss_active_off", 32'(active), 32'd0);
    chk("miss_no_hit", hit_cnt, 32'd1);

    // Block on the same edge as a colliding step.
    wait_to(112); fire = 1'b1; enemy_x = 8'd55; enemy_y = 7'd108; ship_x = 8'd50;
    wait_to(113); fire = 1'b0;
    wait_to(114); chk("blk_y0", 32'(y), 32'd108);
    wait_to(119); blocked = 1'b1;
    wait_to(120); blocked = 1'b0;
    chk("blk_y_held", 32'(y), 32'd108);
    wait_to(121); chk("blk_active_off", 32'(active), 32'd0);
    wait_to(123); chk("blk_no_hit", hit_cnt, 32'd1);

    // Spawn at the bottom row, then fire held across cooldown.
    wait_to(128); fire = 1'b1; enemy_x = 8'd7; enemy_y = 7'd116;
    wait_to(130);
    chk("spawn_active", 32'(active), 32'd1);
    chk("spawn_y", 32'(y), 32'd116);
    chk("spawn_x", 32'(x), 32'd7);
    chk("spawn_mvd", 32'(mv_d), 32'd0);
    wait_to(131);
    chk("spawn_one_cycle", 32'(active), 32'd0);
    enemy_y = 7'd40;
    act_hi = 32'd0;
    for (int k = 132; k <= 137; k++) begin
      wait_to(k);
      if (active !== 1'b0) act_hi = act_hi + 32'd1;
    end
    chk("cool_gap_active", act_hi, 32'd0);
    wait_to(138); fire = 1'b0;
    chk("refire_active", 32'(active), 32'd1);
    chk("refire_y", 32'(y), 32'd40);

    // Reset while in flight at row 40.
    wait_to(140);
    chk("midflight_y", 32'(y), 32'd40);
    resetn = 1'b0;
    #1;
    chk("midrst_x", 32'(x), 32'd0);
    chk("midrst_y", 32'(y), 32'd0);
    chk("midrst_active", 32'(active), 32'd0);
    chk("midrst_mvd", 32'(mv_d), 32'd0);
    chk("midrst_hit", 32'(player_hit), 32'd0);
    @(negedge clk);
    resetn = 1'b1; fire = 1'b1; enemy_x = 8'd3; enemy_y = 7'd10;
    wait_to(1); fire = 1'b0;
    wait_to(2);
    chk("postrst_active", 32'(active), 32'd1);
    chk("postrst_x", 32'(x), 32'd3);
    chk("postrst_y", 32'(y), 32'd10);
    wait_to(3);
    chk("postrst_mvd", 32'(mv_d), 32'd1);
    chk("total_hits", hit_cnt, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
